axi_mem_device: RTL and testbench

AXI_MEM_DEVICE -- requirements
Module: axi_mem_device

---
 rtl/axi_mem_device.sv | 262 ++++++++++++++++++++++++++
 tb/tb_axi_mem_device.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_device.sv
// axi_mem_device: AXI responder backed by an internal word-addressed memory.
//
// Ports:
//   clk_i, rst_ni      - clock (rising edge) and asynchronous active-low reset
//   dev_aw_*           - write address channel (valid/ready handshake)
//   dev_w_*            - write data channel with byte strobes and last flag
//   dev_b_*            - write response channel
//   dev_ar_*           - read address channel
//   dev_r_*            - read data channel
//
// The read and write paths are independent state machines. Each beat is
// checked for a supported size, a supported burst type (FIXED/INCR) and an
// in-range word index; erring beats never touch memory and return SLVERR.
// Memory contents are deliberately not reset.
module axi_mem_device #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 1,
    parameter int unsigned Depth     = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    // write address
    input  logic [IdWidth-1:0]     dev_aw_id,
    input  logic [AddrWidth-1:0]   dev_aw_addr,
    input  logic [7:0]             dev_aw_len,
    input  logic [2:0]             dev_aw_size,
    input  logic [1:0]             dev_aw_burst,
    input  logic                   dev_aw_valid,
    output logic                   dev_aw_ready,
    // write data
    input  logic [DataWidth-1:0]   dev_w_data,
    input  logic [DataWidth/8-1:0] dev_w_strb,
    input  logic                   dev_w_last,
    input  logic                   dev_w_valid,
    output logic                   dev_w_ready,
    // write response
    output logic [IdWidth-1:0]     dev_b_id,
    output logic [1:0]             dev_b_resp,
    output logic                   dev_b_user,
    output logic                   dev_b_valid,
    input  logic                   dev_b_ready,
    // read address
    input  logic [IdWidth-1:0]     dev_ar_id,
    input  logic [AddrWidth-1:0]   dev_ar_addr,
    input  logic [7:0]             dev_ar_len,
    input  logic [2:0]             dev_ar_size,
    input  logic [1:0]             dev_ar_burst,
    input  logic                   dev_ar_valid,
    output logic                   dev_ar_ready,
    // read data
    output logic [IdWidth-1:0]     dev_r_id,
    output logic [DataWidth-1:0]   dev_r_data,
    output logic [1:0]             dev_r_resp,
    output logic                   dev_r_last,
    output logic                   dev_r_user,
    output logic                   dev_r_valid,
    input  logic                   dev_r_ready
);

    localparam int unsigned NonBurstSize = $clog2(DataWidth / 8);
    localparam int unsigned StrbWidth    = DataWidth / 8;
    localparam int unsigned IdxWidth     = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [AddrWidth-1:0] BeatBytes = AddrWidth'(StrbWidth);

    localparam logic [1:0] BurstIncr = 2'b01;
    localparam logic [1:0] RespOkay  = 2'b00;
    localparam logic [1:0] RespSlv   = 2'b10;

    typedef enum logic {R_IDLE = 1'b0, R_BUSY = 1'b1} rd_state_e;
    typedef enum logic [1:0] {W_IDLE = 2'b00, W_BUSY = 2'b01, W_RESP = 2'b10} wr_state_e;

    // A beat errs on unsupported size, WRAP/reserved burst (burst[1] set) or
    // a word index beyond the storage.
    function automatic logic beat_err(input logic [2:0]           size,
                                      input logic [1:0]           burst,
                                      input logic [AddrWidth-1:0] word);
        return (size != 3'(NonBurstSize)) || burst[1] || (word >= AddrWidth'(Depth));
    endfunction

    logic [DataWidth-1:0] mem_r [Depth];

    // ---------------------------------------------------------------- read
    rd_state_e            rd_state_r, rd_state_s;
    logic [AddrWidth-1:0] rd_addr_r;
    logic [7:0]           rd_len_r;
    logic [2:0]           rd_size_r;
    logic [1:0]           rd_burst_r;
    logic [IdWidth-1:0]   rd_id_r;
    logic [7:0]           rd_cnt_r;
    logic [AddrWidth-1:0] rd_word_s;
    logic [IdxWidth-1:0]  rd_idx_s;
    logic                 rd_err_s;
    logic                 rd_last_s;

    assign rd_word_s = rd_addr_r >> NonBurstSize;
    assign rd_idx_s  = rd_word_s[IdxWidth-1:0];
    assign rd_err_s  = beat_err(rd_size_r, rd_burst_r, rd_word_s);
    assign rd_last_s = (rd_cnt_r == rd_len_r);

    // Read state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_state_r <= R_IDLE;
        end else begin
            rd_state_r <= rd_state_s;
        end
    end

    // Read next-state logic.
    always_comb begin
        rd_state_s = rd_state_r;
        case (rd_state_r)
            R_IDLE: begin
                if (dev_ar_valid) rd_state_s = R_BUSY;
                else              rd_state_s = R_IDLE;
            end
            R_BUSY: begin
                if (dev_r_ready && rd_last_s) rd_state_s = R_IDLE;
                else                          rd_state_s = R_BUSY;
            end
            default: rd_state_s = R_IDLE;
        endcase
    end

    // Read burst context: latch on AR handshake, advance on each R handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_addr_r  <= '0;
            rd_len_r   <= 8'd0;
            rd_size_r  <= 3'd0;
            rd_burst_r <= 2'd0;
            rd_id_r    <= '0;
            rd_cnt_r   <= 8'd0;
        end else if (rd_state_r == R_IDLE && dev_ar_valid) begin
            rd_addr_r  <= dev_ar_addr;
            rd_len_r   <= dev_ar_len;
            rd_size_r  <= dev_ar_size;
            rd_burst_r <= dev_ar_burst;
            rd_id_r    <= dev_ar_id;
            rd_cnt_r   <= 8'd0;
        end else if (rd_state_r == R_BUSY && dev_r_ready) begin
            rd_cnt_r  <= rd_cnt_r + 8'd1;
            rd_addr_r <= (rd_burst_r == BurstIncr) ? rd_addr_r + BeatBytes : rd_addr_r;
        end
    end

    // Read channel outputs; data is taken combinationally so a same-cycle
    // write commit is seen only on the following beat.
    always_comb begin
        dev_ar_ready = (rd_state_r == R_IDLE);
        dev_r_valid  = (rd_state_r == R_BUSY);
        dev_r_id     = rd_id_r;
        dev_r_last   = rd_last_s;
        dev_r_user   = 1'b0;
        if (rd_err_s) begin
            dev_r_data = '0;
            dev_r_resp = RespSlv;
        end else begin
            dev_r_data = mem_r[rd_idx_s];
            dev_r_resp = RespOkay;
        end
    end

    // --------------------------------------------------------------- write
    wr_state_e            wr_state_r, wr_state_s;
    logic [AddrWidth-1:0] wr_addr_r;
    logic [7:0]           wr_len_r;
    logic [2:0]           wr_size_r;
    logic [1:0]           wr_burst_r;
    logic [IdWidth-1:0]   wr_id_r;
    logic [8:0]           wr_cnt_r;   // saturates at 256 so beats past len stay flagged
    logic                 wr_err_r;
    logic [AddrWidth-1:0] wr_word_s;
    logic [IdxWidth-1:0]  wr_idx_s;
    logic                 wr_beat_err_s;
    logic                 wr_over_s;
    logic                 wr_hs_s;
    logic                 wr_commit_s;

    assign wr_word_s     = wr_addr_r >> NonBurstSize;
    assign wr_idx_s      = wr_word_s[IdxWidth-1:0];
    assign wr_beat_err_s = beat_err(wr_size_r, wr_burst_r, wr_word_s);
    assign wr_over_s     = (wr_cnt_r > {1'b0, wr_len_r});
    assign wr_hs_s       = (wr_state_r == W_BUSY) && dev_w_valid;
    assign wr_commit_s   = wr_hs_s && !wr_beat_err_s && !wr_over_s;

    // Write state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_state_r <= W_IDLE;
        end else begin
            wr_state_r <= wr_state_s;
        end
    end

    // Write next-state logic; the burst ends on W last regardless of len.
    always_comb begin
        wr_state_s = wr_state_r;
        case (wr_state_r)
            W_IDLE: begin
                if (dev_aw_valid) wr_state_s = W_BUSY;
                else              wr_state_s = W_IDLE;
            end
            W_BUSY: begin
                if (dev_w_valid && dev_w_last) wr_state_s = W_RESP;
                else                           wr_state_s = W_BUSY;
            end
            W_RESP: begin
                if (dev_b_ready) wr_state_s = W_IDLE;
                else             wr_state_s = W_RESP;
            end
            default: wr_state_s = W_IDLE;
        endcase
    end

    // Write burst context and sticky error accumulation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_addr_r  <= '0;
            wr_len_r   <= 8'd0;
            wr_size_r  <= 3'd0;
            wr_burst_r <= 2'd0;
            wr_id_r    <= '0;
            wr_cnt_r   <= 9'd0;
            wr_err_r   <= 1'b0;
        end else if (wr_state_r == W_IDLE && dev_aw_valid) begin
            wr_addr_r  <= dev_aw_addr;
            wr_len_r   <= dev_aw_len;
            wr_size_r  <= dev_aw_size;
            wr_burst_r <= dev_aw_burst;
            wr_id_r    <= dev_aw_id;
            wr_cnt_r   <= 9'd0;
            wr_err_r   <= 1'b0;
        end else if (wr_hs_s) begin
            wr_cnt_r  <= (wr_cnt_r == 9'd256) ? wr_cnt_r : wr_cnt_r + 9'd1;
            wr_err_r  <= wr_err_r | wr_beat_err_s | wr_over_s;
            wr_addr_r <= (wr_burst_r == BurstIncr) ? wr_addr_r + BeatBytes : wr_addr_r;
        end
    end

    // Write channel outputs.
    always_comb begin
        dev_aw_ready = (wr_state_r == W_IDLE);
        dev_w_ready  = (wr_state_r == W_BUSY);
        dev_b_valid  = (wr_state_r == W_RESP);
        dev_b_id     = wr_id_r;
        dev_b_user   = 1'b0;
        if (wr_err_r) dev_b_resp = RespSlv;
        else          dev_b_resp = RespOkay;
    end

    // Storage: byte-strobed commit, no reset so contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (wr_commit_s) begin
            for (int b = 0; b < int'(StrbWidth); b++) begin
                if (dev_w_strb[b]) mem_r[wr_idx_s][8*b +: 8] <= dev_w_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_device.sv
module tb_axi_mem_device;

    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [0:0]  dev_aw_id;
    logic [63:0] dev_aw_addr;
    logic [7:0]  dev_aw_len;
    logic [2:0]  dev_aw_size;
    logic [1:0]  dev_aw_burst;
    logic        dev_aw_valid;
    logic        dev_aw_ready;
    logic [63:0] dev_w_data;
    logic [7:0]  dev_w_strb;
    logic        dev_w_last;
    logic        dev_w_valid;
    logic        dev_w_ready;
    logic [0:0]  dev_b_id;
    logic [1:0]  dev_b_resp;
    logic        dev_b_user;
    logic        dev_b_valid;
    logic        dev_b_ready;
    logic [0:0]  dev_ar_id;
    logic [63:0] dev_ar_addr;
    logic [7:0]  dev_ar_len;
    logic [2:0]  dev_ar_size;
    logic [1:0]  dev_ar_burst;
    logic        dev_ar_valid;
    logic        dev_ar_ready;
    logic [0:0]  dev_r_id;
    logic [63:0] dev_r_data;
    logic [1:0]  dev_r_resp;
    logic        dev_r_last;
    logic        dev_r_user;
    logic        dev_r_valid;
    logic        dev_r_ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] wdata     [16];
    logic [63:0] rexp_data [16];
    logic [1:0]  rexp_resp [16];

    always #5 clk_i = ~clk_i;

    axi_mem_device #(.AddrWidth(64), .DataWidth(64), .IdWidth(1), .Depth(1024)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .dev_aw_id(dev_aw_id), .dev_aw_addr(dev_aw_addr), .dev_aw_len(dev_aw_len),
        .dev_aw_size(dev_aw_size), .dev_aw_burst(dev_aw_burst),
        .dev_aw_valid(dev_aw_valid), .dev_aw_ready(dev_aw_ready),
        .dev_w_data(dev_w_data), .dev_w_strb(dev_w_strb), .dev_w_last(dev_w_last),
        .dev_w_valid(dev_w_valid), .dev_w_ready(dev_w_ready),
        .dev_b_id(dev_b_id), .dev_b_resp(dev_b_resp), .dev_b_user(dev_b_user),
        .dev_b_valid(dev_b_valid), .dev_b_ready(dev_b_ready),
        .dev_ar_id(dev_ar_id), .dev_ar_addr(dev_ar_addr), .dev_ar_len(dev_ar_len),
        .dev_ar_size(dev_ar_size), .dev_ar_burst(dev_ar_burst),
        .dev_ar_valid(dev_ar_valid), .dev_ar_ready(dev_ar_ready),
        .dev_r_id(dev_r_id), .dev_r_data(dev_r_data), .dev_r_resp(dev_r_resp),
        .dev_r_last(dev_r_last), .dev_r_user(dev_r_user),
        .dev_r_valid(dev_r_valid), .dev_r_ready(dev_r_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full write burst: AW, nbeats W beats from wdata[] (last on the final one), then B.
    task automatic wr_burst(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic id, input int nbeats, input logic [7:0] strb,
                            input logic [1:0] exp_resp);
        dev_aw_addr  = addr;
        dev_aw_len   = len;
        dev_aw_size  = 3'd3;
        dev_aw_burst = burst;
        dev_aw_id    = id;
        dev_aw_valid = 1'b1;
        for (int t = 0; t < 100 && !dev_aw_ready; t++) @(negedge clk_i);
        chk("aw_ready", 64'(dev_aw_ready), 64'd1);
        @(negedge clk_i);
        dev_aw_valid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            dev_w_data  = wdata[i];
            dev_w_strb  = strb;
            dev_w_last  = (i == nbeats - 1);
            dev_w_valid = 1'b1;
            for (int t = 0; t < 100 && !dev_w_ready; t++) @(negedge clk_i);
            chk($sformatf("w_ready[%0d]", i), 64'(dev_w_ready), 64'd1);
            @(negedge clk_i);
        end
        dev_w_valid = 1'b0;
        dev_w_last  = 1'b0;
        dev_b_ready = 1'b1;
        for (int t = 0; t < 100 && !dev_b_valid; t++) @(negedge clk_i);
        chk("b_valid", 64'(dev_b_valid), 64'd1);
        chk("b_resp", 64'(dev_b_resp), 64'(exp_resp));
        chk("b_id", 64'(dev_b_id), 64'(id));
        chk("b_user", 64'(dev_b_user), 64'd0);
        @(negedge clk_i);
        dev_b_ready = 1'b0;
        chk("b_valid_after", 64'(dev_b_valid), 64'd0);
    endtask

    // Full read burst with r_ready held high, checked against rexp_*[].
    task automatic rd_burst(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic id);
        dev_ar_addr  = addr;
        dev_ar_len   = len;
        dev_ar_size  = 3'd3;
        dev_ar_burst = burst;
        dev_ar_id    = id;
        dev_ar_valid = 1'b1;
        for (int t = 0; t < 100 && !dev_ar_ready; t++) @(negedge clk_i);
        chk("ar_ready", 64'(dev_ar_ready), 64'd1);
        @(negedge clk_i);
        dev_ar_valid = 1'b0;
        dev_r_ready  = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            for (int t = 0; t < 100 && !dev_r_valid; t++) @(negedge clk_i);
            chk($sformatf("r_valid[%0d]", i), 64'(dev_r_valid), 64'd1);
            chk($sformatf("r_data[%0d]", i), dev_r_data, rexp_data[i]);
            chk($sformatf("r_resp[%0d]", i), 64'(dev_r_resp), 64'(rexp_resp[i]));
            chk($sformatf("r_last[%0d]", i), 64'(dev_r_last), 64'(i == int'(len)));
            chk($sformatf("r_id[%0d]", i), 64'(dev_r_id), 64'(id));
            @(negedge clk_i);
        end
        dev_r_ready = 1'b0;
        chk("r_idle", 64'(dev_r_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] prev_data;
        logic        prev_last;
        logic        stalled;
        logic        rdy;
        logic [3:0]  pat;
        int          hs;

        rst_ni       = 1'b0;
        dev_aw_id    = 1'b0; dev_aw_addr = 64'd0; dev_aw_len = 8'd0; dev_aw_size = 3'd3;
        dev_aw_burst = INCR; dev_aw_valid = 1'b0;
        dev_w_data   = 64'd0; dev_w_strb = 8'h00; dev_w_last = 1'b0; dev_w_valid = 1'b0;
        dev_b_ready  = 1'b0;
        dev_ar_id    = 1'b0; dev_ar_addr = 64'd0; dev_ar_len = 8'd0; dev_ar_size = 3'd3;
        dev_ar_burst = INCR; dev_ar_valid = 1'b0;
        dev_r_ready  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_ar_ready", 64'(dev_ar_ready), 64'd1);
        chk("rst_aw_ready", 64'(dev_aw_ready), 64'd1);
        chk("rst_r_valid", 64'(dev_r_valid), 64'd0);
        chk("rst_w_ready", 64'(dev_w_ready), 64'd0);
        chk("rst_b_valid", 64'(dev_b_valid), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Basic 4-beat INCR write then read-back
        for (int i = 0; i < 4; i++) begin
            wdata[i] = 64'(i + 1); rexp_data[i] = 64'(i + 1); rexp_resp[i] = OKAY;
        end
        wr_burst(64'h100, 8'd3, INCR, 1'b1, 4, 8'hFF, OKAY);
        rd_burst(64'h100, 8'd3, INCR, 1'b1);

        // R backpressure with ready pattern 1,0,0,1 then 1s
        pat          = 4'b1001;
        dev_ar_addr  = 64'h100; dev_ar_len = 8'd3; dev_ar_burst = INCR; dev_ar_id = 1'b0;
        dev_ar_valid = 1'b1;
        @(negedge clk_i);
        dev_ar_valid = 1'b0;
        hs = 0; stalled = 1'b0; prev_data = 64'd0; prev_last = 1'b0;
        for (int c = 0; c < 20 && hs < 4; c++) begin
            rdy = (c < 4) ? pat[3 - c] : 1'b1;
            dev_r_ready = rdy;
            if (stalled) begin
                chk($sformatf("bp_stable_data[%0d]", c), dev_r_data, prev_data);
                chk($sformatf("bp_stable_last[%0d]", c), 64'(dev_r_last), 64'(prev_last));
            end
            if (dev_r_valid && rdy) begin
                chk($sformatf("bp_data[%0d]", hs), dev_r_data, 64'(hs + 1));
                chk($sformatf("bp_last[%0d]", hs), 64'(dev_r_last), 64'(hs == 3));
                hs++;
            end
            stalled   = dev_r_valid && !rdy;
            prev_data = dev_r_data;
            prev_last = dev_r_last;
            @(negedge clk_i);
        end
        dev_r_ready = 1'b0;
        chk("bp_handshakes", 64'(hs), 64'd4);
        chk("bp_idle", 64'(dev_r_valid), 64'd0);

        // Byte strobes
        wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        wr_burst(64'h300, 8'd0, INCR, 1'b0, 1, 8'hFF, OKAY);
        wdata[0] = 64'h0;
        wr_burst(64'h300, 8'd0, INCR, 1'b0, 1, 8'h0F, OKAY);
        rexp_data[0] = 64'hFFFF_FFFF_0000_0000; rexp_resp[0] = OKAY;
        rd_burst(64'h300, 8'd0, INCR, 1'b0);

        // Read crossing the top of memory: second beat out of range
        wdata[0] = 64'h55;
        wr_burst(64'h1FF8, 8'd0, INCR, 1'b0, 1, 8'hFF, OKAY);
        rexp_data[0] = 64'h55; rexp_resp[0] = OKAY;
        rexp_data[1] = 64'h0;  rexp_resp[1] = SLVERR;
        rd_burst(64'h1FF8, 8'd1, INCR, 1'b1);

        // WRAP write rejected, memory unchanged
        wdata[0] = 64'hDEAD;
        wr_burst(64'h100, 8'd0, WRAP, 1'b1, 1, 8'hFF, SLVERR);
        rexp_data[0] = 64'h1; rexp_resp[0] = OKAY;
        rd_burst(64'h100, 8'd0, INCR, 1'b0);

        // FIXED read: same word on every beat
        rexp_data[0] = 64'h2; rexp_data[1] = 64'h2; rexp_resp[1] = OKAY;
        rexp_resp[0] = OKAY;
        rd_burst(64'h108, 8'd1, FIXED, 1'b0);

        // Extra W beat past len: discarded, SLVERR
        wdata[0] = 64'h11; wdata[1] = 64'h99;
        wr_burst(64'h400, 8'd1, INCR, 1'b0, 2, 8'hFF, OKAY);
        wdata[0] = 64'h7; wdata[1] = 64'h8;
        wr_burst(64'h400, 8'd0, INCR, 1'b1, 2, 8'hFF, SLVERR);
        rexp_data[0] = 64'h7; rexp_data[1] = 64'h99;
        rexp_resp[0] = OKAY;  rexp_resp[1] = OKAY;
        rd_burst(64'h400, 8'd1, INCR, 1'b0);

        // Concurrent 16-beat write and read on one region: read sees old data
        for (int i = 0; i < 16; i++) wdata[i] = 64'hA000 + 64'(i);
        wr_burst(64'h800, 8'd15, INCR, 1'b0, 16, 8'hFF, OKAY);
        for (int i = 0; i < 16; i++) begin
            rexp_data[i] = 64'hA000 + 64'(i); rexp_resp[i] = OKAY;
            wdata[i]     = 64'hB000 + 64'(i);
        end
        fork
            wr_burst(64'h800, 8'd15, INCR, 1'b0, 16, 8'hFF, OKAY);
            rd_burst(64'h800, 8'd15, INCR, 1'b1);
        join
        for (int i = 0; i < 16; i++) rexp_data[i] = 64'hB000 + 64'(i);
        rd_burst(64'h800, 8'd15, INCR, 1'b0);

        // Reset in the middle of an 8-beat read after two beats
        dev_ar_addr  = 64'h800; dev_ar_len = 8'd7; dev_ar_burst = INCR; dev_ar_id = 1'b1;
        dev_ar_valid = 1'b1;
        @(negedge clk_i);
        dev_ar_valid = 1'b0;
        dev_r_ready  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("mid_r_valid[%0d]", i), 64'(dev_r_valid), 64'd1);
            chk($sformatf("mid_r_data[%0d]", i), dev_r_data, 64'hB000 + 64'(i));
            @(negedge clk_i);
        end
        rst_ni      = 1'b0;
        dev_r_ready = 1'b0;
        #1;
        chk("mid_rst_r_valid", 64'(dev_r_valid), 64'd0);
        chk("mid_rst_ar_ready", 64'(dev_ar_ready), 64'd1);
        @(negedge clk_i);
        chk("mid_rst_r_valid_hold", 64'(dev_r_valid), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_r_valid", 64'(dev_r_valid), 64'd0);
        rexp_data[0] = 64'hB002; rexp_data[1] = 64'hB003;
        rexp_resp[0] = OKAY;     rexp_resp[1] = OKAY;
        rd_burst(64'h810, 8'd1, INCR, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
